// File: rtl/alu_issue_controller.sv
// Issue controller for one combinational ALU lane: queues commands in order, drives the
// ALU for a single cycle per command, and returns the captured result with its tag.
module alu_issue_controller #(
    parameter int CMD_DEPTH = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic [7:0]            cmd_opcode_in,
    input  logic signed [7:0]     cmd_a_in,
    input  logic signed [7:0]     cmd_b_in,
    input  logic [TAG_WIDTH-1:0]  cmd_tag_in,
    output logic                  alu_enable_out,
    output logic [7:0]            alu_opcode_out,
    output logic signed [7:0]     alu_a_out,
    output logic signed [7:0]     alu_b_out,
    input  logic signed [7:0]     alu_result_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic signed [7:0]     rsp_data_out,
    output logic [TAG_WIDTH-1:0]  rsp_tag_out,
    output logic                  rsp_err_out,
    output logic [15:0]           ops_done_out
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(CMD_DEPTH);
    localparam logic [7:0] OP_MAX = 8'd4;

    typedef struct packed {
        logic [7:0]           op;
        logic [7:0]           a;
        logic [7:0]           b;
        logic [TAG_WIDTH-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    cmd_t             fifo_q [CMD_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    state_t           state_q, state_d;
    cmd_t             iss_q;
    logic [7:0]       rsp_data_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;
    logic             rsp_err_q;
    logic [15:0]      ops_done_q;
    logic             push, pop, legal, rsp_hs;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign cmd_ready_out = (count_q != DEPTH_C);
    assign push          = cmd_valid_in && cmd_ready_out;
    assign legal         = (iss_q.op <= OP_MAX);
    assign rsp_hs        = (state_q == S_RESP) && rsp_ready_in;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{op: cmd_opcode_in, a: cmd_a_in, b: cmd_b_in, tag: cmd_tag_in};
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // State register
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_in) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ALU port is only driven during the single issue cycle.
    always_comb begin
        alu_enable_out = 1'b0;
        alu_opcode_out = '0;
        alu_a_out      = '0;
        alu_b_out      = '0;
        rsp_valid_out  = 1'b0;
        case (state_q)
            S_ISSUE: begin
                alu_enable_out = legal;
                alu_opcode_out = iss_q.op;
                alu_a_out      = iss_q.a;
                alu_b_out      = iss_q.b;
            end
            S_RESP:  rsp_valid_out = 1'b1;
            default: rsp_valid_out = 1'b0;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            iss_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            if (pop) iss_q <= fifo_q[rd_ptr_q];
            if (state_q == S_ISSUE) begin
                rsp_data_q <= legal ? alu_result_in : 8'd0;
                rsp_tag_q  <= iss_q.tag;
                rsp_err_q  <= !legal;
            end
            if (rsp_hs) ops_done_q <= ops_done_q + 16'd1;
        end
    end

    assign rsp_data_out = rsp_data_q;
    assign rsp_tag_out  = rsp_tag_q;
    assign rsp_err_out  = rsp_err_q;
    assign ops_done_out = ops_done_q;
endmodule

// File: tb/tb_alu_issue_controller.sv
// Scoreboard bench for alu_issue_controller with a behavioural ALU attached to the ALU port.
module tb_alu_issue_controller;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_ready_out;
    logic [7:0]    cmd_opcode_in = '0;
    logic [7:0]    cmd_a_in = '0;
    logic [7:0]    cmd_b_in = '0;
    logic [TW-1:0] cmd_tag_in = '0;
    logic          alu_enable_out;
    logic [7:0]    alu_opcode_out, alu_a_out, alu_b_out;
    logic [7:0]    alu_result_in;
    logic          rsp_valid_out;
    logic          rsp_ready_in = 1'b0;
    logic [7:0]    rsp_data_out;
    logic [TW-1:0] rsp_tag_out;
    logic          rsp_err_out;
    logic [15:0]   ops_done_out;

    typedef struct {
        logic [7:0]    data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc[$];
    int   total = 0, bad = 0, hs = 0, cyc = 0, rdy_mode = 0;
    bit   prev_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue_controller #(.CMD_DEPTH(4), .TAG_WIDTH(TW)) dut (
        .clock_in(clk), .reset_in(rst),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_opcode_in(cmd_opcode_in), .cmd_a_in(cmd_a_in), .cmd_b_in(cmd_b_in),
        .cmd_tag_in(cmd_tag_in),
        .alu_enable_out(alu_enable_out), .alu_opcode_out(alu_opcode_out),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_result_in(alu_result_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out), .rsp_err_out(rsp_err_out),
        .ops_done_out(ops_done_out)
    );

    // ALU lane: garbage when disabled, so a wrongly captured result is visible.
    always_comb begin
        alu_result_in = 8'h5A;
        if (alu_enable_out) begin
            case (alu_opcode_out)
                8'd0:    alu_result_in = alu_a_out + alu_b_out;
                8'd1:    alu_result_in = alu_a_out - alu_b_out;
                8'd2:    alu_result_in = alu_a_out * alu_b_out;
                8'd3:    alu_result_in = {7'd0, alu_a_out == alu_b_out};
                8'd4:    alu_result_in = {7'd0, $signed(alu_a_out) > $signed(alu_b_out)};
                default: alu_result_in = 8'hA5;
            endcase
        end
    end

    // Expected result from integer arithmetic on the command as issued.
    function automatic logic [7:0] ref_res(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        int x, y, r;
        x = $signed(a);
        y = $signed(b);
        case (op)
            8'd0:    r = x + y;
            8'd1:    r = x - y;
            8'd2:    r = x * y;
            8'd3:    r = (x == y) ? 1 : 0;
            8'd4:    r = (x > y) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [TW-1:0] tag);
        exp_t e;
        cmd_valid_in  = 1'b1;
        cmd_opcode_in = op;
        cmd_a_in      = a;
        cmd_b_in      = b;
        cmd_tag_in    = tag;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (cmd_ready_out) begin
                e.data = ref_res(op, a, b);
                e.tag  = tag;
                e.err  = (op > 8'd4);
                sb.push_back(e);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 32'd0, 32'd1);
        cmd_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        cyc_wait(3);
    endtask

    initial begin
        exp_t e;
        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(posedge clk);
                #2;
                case (rdy_mode)
                    0:       rsp_ready_in = 1'b0;
                    1:       rsp_ready_in = 1'b1;
                    default: rsp_ready_in = 1'($urandom_range(0, 1));
                endcase
            end
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (alu_enable_out && prev_en) chk("enable_one_cycle", 32'd1, 32'd0);
                    if (alu_enable_out && alu_opcode_out > 8'd4) chk("enable_illegal", 32'd1, 32'd0);
                    prev_en = alu_enable_out;
                    if (rsp_valid_out && rsp_ready_in) begin
                        hs_cyc.push_back(cyc);
                        if (sb.size() == 0) begin
                            chk("unexpected_rsp", {28'd0, rsp_tag_out}, 32'hFFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_data", rsp_data_out, e.data);
                            chk("rsp_tag", rsp_tag_out, e.tag);
                            chk("rsp_err", rsp_err_out, e.err);
                            chk("ops_done_pre", ops_done_out, hs);
                        end
                        hs++;
                    end
                end else begin
                    prev_en = 1'b0;
                end
            end
        join_none

        // T1: reset state
        #3;
        chk("t1_cmd_ready", cmd_ready_out, 1);
        chk("t1_rsp_valid", rsp_valid_out, 0);
        chk("t1_alu_en", alu_enable_out, 0);
        chk("t1_alu_fields", {alu_opcode_out, alu_a_out, alu_b_out}, 0);
        chk("t1_rsp_fields", {rsp_data_out, rsp_tag_out, rsp_err_out}, 0);
        chk("t1_ops", ops_done_out, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc_wait(2);
        chk("t1_idle_en", alu_enable_out, 0);
        chk("t1_idle_valid", rsp_valid_out, 0);

        // T2: single ADD, latency and enable pulse
        send(8'd0, 8'd5, 8'd3, 4'd1);
        cmd_valid_in = 1'b0;
        chk("t2_no_early_rsp", rsp_valid_out, 0);
        chk("t2_no_early_en", alu_enable_out, 0);
        @(negedge clk);
        chk("t2_issue_en", alu_enable_out, 1);
        chk("t2_issue_ops", {alu_opcode_out, alu_a_out, alu_b_out}, {8'd0, 8'd5, 8'd3});
        chk("t2_issue_no_rsp", rsp_valid_out, 0);
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid_out, 1);
        chk("t2_en_dropped", alu_enable_out, 0);
        chk("t2_rsp_data", rsp_data_out, 8'd8);
        rdy_mode = 1;
        cyc_wait(4);
        chk("t2_ops_done", ops_done_out, 1);

        // T3: back-to-back with rsp_ready held high
        hs_cyc.delete();
        send(8'd1, 8'd3, 8'd5, 4'd2);
        send(8'd2, 8'd16, 8'd16, 4'd3);
        send(8'd4, 8'hFF, 8'd1, 4'd4);
        send(8'd3, 8'hF9, 8'hF9, 4'd5);
        cmd_valid_in = 1'b0;
        drain();
        chk("t3_count", hs_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++) chk("t3_spacing", hs_cyc[i] - hs_cyc[i-1], 2);

        // T4: backpressure fills issue slot plus FIFO
        rdy_mode = 0;
        cyc_wait(2);
        for (int t = 0; t < 5; t++)
            send(8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), TW'(t));
        cmd_valid_in  = 1'b1;
        cmd_opcode_in = 8'd0;
        cmd_a_in      = 8'd100;
        cmd_b_in      = 8'd100;
        cmd_tag_in    = 4'd5;
        #1;
        chk("t4_full", cmd_ready_out, 0);
        cyc_wait(2);
        #1;
        chk("t4_still_full", cmd_ready_out, 0);
        @(negedge clk);
        rdy_mode = 1;
        send(8'd0, 8'd100, 8'd100, 4'd5);
        cmd_valid_in = 1'b0;
        drain();

        // T5: illegal opcode
        send(8'd7, 8'd9, 8'd9, 4'd3);
        cmd_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_en_low", alu_enable_out, 0);
            @(negedge clk);
        end
        drain();

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            send(op, 8'($urandom), 8'($urandom), TW'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid_in = 1'b0;
                cyc_wait($urandom_range(1, 3));
            end
        end
        cmd_valid_in = 1'b0;
        rdy_mode = 1;
        drain();

        // T6: reset while holding a response with two commands queued
        rdy_mode = 0;
        cyc_wait(2);
        send(8'd0, 8'd1, 8'd1, 4'd7);
        send(8'd0, 8'd2, 8'd2, 4'd8);
        send(8'd0, 8'd3, 8'd3, 4'd9);
        cmd_valid_in = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid_out; i++) @(negedge clk);
        chk("t6_in_resp", rsp_valid_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_clr", rsp_valid_out, 0);
        chk("t6_ready", cmd_ready_out, 1);
        chk("t6_ops_clr", ops_done_out, 0);
        chk("t6_en_clr", alu_enable_out, 0);
        sb.delete();
        hs = 0;
        cyc_wait(2);
        rst = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_quiet", rsp_valid_out, 0);
        end
        chk("t6_ops_after", ops_done_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
